// File: rtl/seven_seg_scan_if.sv
// Bundle between score logic and the seven-segment scan driver.
// The slave modport is the driver; the master modport is its user.
interface seven_seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BRIGHT_W   = 3
);
  logic [4*NUM_DIGITS-1:0] DIGITS_IN;
  logic [NUM_DIGITS-1:0]   DOTS_IN;
  logic                    LOAD_IN;
  logic [NUM_DIGITS-1:0]   DIGIT_EN_IN;
  logic                    BLANK_LZ_IN;
  logic [BRIGHT_W-1:0]     BRIGHTNESS_IN;
  logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT;
  logic [7:0]              HEX_OUT;
  logic                    SLOT_TICK_OUT;

  modport master (
    output DIGITS_IN, DOTS_IN, LOAD_IN, DIGIT_EN_IN, BLANK_LZ_IN, BRIGHTNESS_IN,
    input  SEG_SELECT_OUT, HEX_OUT, SLOT_TICK_OUT
  );

  modport slave (
    input  DIGITS_IN, DOTS_IN, LOAD_IN, DIGIT_EN_IN, BLANK_LZ_IN, BRIGHTNESS_IN,
    output SEG_SELECT_OUT, HEX_OUT, SLOT_TICK_OUT
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with shadowed digits,
// per-digit enable, leading-zero blanking, PWM brightness and a dead cycle per slot.
module seven_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BRIGHT_W    = 3
) (
  input  logic            CLK,
  input  logic            RESET,
  seven_seg_scan_if.slave bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIG_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
  logic [DIG_W-1:0]      nib_q, nib_d;
  logic [NUM_DIGITS-1:0] dot_q, dot_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            hex_q, hex_d;
  logic                  tick_q, tick_d;

  logic [NUM_DIGITS-1:0] blank_c;
  logic                  all_zero_c;
  logic [3:0]            cur_nib_c;
  logic                  cur_dot_c;
  logic                  cur_en_c;
  logic                  cur_blank_c;
  logic                  lit_c;

  function automatic logic [6:0] seg_enc(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Blanking walks down from the most significant digit while nibbles stay zero.
  always_comb begin
    blank_c    = '0;
    all_zero_c = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero_c = all_zero_c && (nib_q[4*i +: 4] == 4'h0);
      blank_c[i] = bus.BLANK_LZ_IN && (i > 0) && all_zero_c;
    end
  end

  always_comb begin
    cur_nib_c   = 4'h0;
    cur_dot_c   = 1'b0;
    cur_en_c    = 1'b0;
    cur_blank_c = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib_c   = nib_q[4*i +: 4];
        cur_dot_c   = dot_q[i];
        cur_en_c    = bus.DIGIT_EN_IN[i];
        cur_blank_c = blank_c[i];
      end
    end
  end

  assign lit_c = (cnt_q != '0) && cur_en_c && (pwm_q <= bus.BRIGHTNESS_IN) && !cur_blank_c;

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    idx_d  = idx_q;
    pwm_d  = pwm_q + BRIGHT_W'(1);
    nib_d  = nib_q;
    dot_d  = dot_q;
    sel_d  = '1;
    hex_d  = 8'hFF;
    tick_d = (cnt_q == '0);

    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    if (bus.LOAD_IN) begin
      nib_d = bus.DIGITS_IN;
      dot_d = bus.DOTS_IN;
    end

    if (lit_c) begin
      sel_d = ~(NUM_DIGITS'(1) << idx_q);
      hex_d = {~cur_dot_c, seg_enc(cur_nib_c)};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pwm_q  <= '0;
      nib_q  <= '0;
      dot_q  <= '0;
      sel_q  <= '1;
      hex_q  <= 8'hFF;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pwm_q  <= pwm_d;
      nib_q  <= nib_d;
      dot_q  <= dot_d;
      sel_q  <= sel_d;
      hex_q  <= hex_d;
      tick_q <= tick_d;
    end
  end

  assign bus.SEG_SELECT_OUT = sel_q;
  assign bus.HEX_OUT        = hex_q;
  assign bus.SLOT_TICK_OUT  = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: a 4-digit instance (REFRESH_DIV=4)
// and a 1-digit instance (REFRESH_DIV=16, BRIGHT_W=2) for brightness and dot.
module tb_seven_seg_scan_driver;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seven_seg_scan_if #(.NUM_DIGITS(4), .BRIGHT_W(3)) bus_a ();
  seven_seg_scan_if #(.NUM_DIGITS(1), .BRIGHT_W(2)) bus_b ();

  seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BRIGHT_W(3)) u_dut_a (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus_a)
  );

  seven_seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(16), .BRIGHT_W(2)) u_dut_b (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reset both instances, release at a falling edge with LOAD high for edge 1.
  task automatic restart(input logic [15:0] digits, input logic [3:0] dots);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_a.DIGITS_IN = digits;
    bus_a.DOTS_IN   = dots;
    bus_a.LOAD_IN   = 1'b1;
    rst = 1'b0;
  endtask

  // Walk the 4-digit instance edge by edge from release; hexv holds digit 3 in the top byte.
  task automatic scan(input string tag, input logic [31:0] hexv, input logic [3:0] lit, input int edges);
    int c, s;
    logic [3:0] exp_sel;
    logic [7:0] exp_hex;
    for (int n = 1; n <= edges; n++) begin
      @(posedge clk);
      #1;
      bus_a.LOAD_IN = 1'b0;
      c = (n - 1) % 4;
      s = ((n - 1) / 4) % 4;
      exp_sel = 4'hF;
      exp_hex = 8'hFF;
      if (c != 0 && lit[s]) begin
        exp_sel = ~(4'b0001 << s);
        exp_hex = hexv[8*s +: 8];
      end
      check({tag, "_tick"}, 32'(bus_a.SLOT_TICK_OUT), 32'(c == 0));
      check({tag, "_sel"},  32'(bus_a.SEG_SELECT_OUT), 32'(exp_sel));
      check({tag, "_hex"},  32'(bus_a.HEX_OUT), 32'(exp_hex));
    end
  endtask

  task automatic bright(input string tag, input logic [1:0] br, input int exp_count);
    int c, p, count;
    logic lit;
    bus_b.BRIGHTNESS_IN = br;
    count = 0;
    restart(16'h1234, 4'h0);
    for (int n = 1; n <= 32; n++) begin
      @(posedge clk);
      #1;
      bus_a.LOAD_IN = 1'b0;
      c = (n - 1) % 16;
      p = (n - 1) % 4;
      lit = (c != 0) && (p <= int'(br));
      if (bus_b.SEG_SELECT_OUT == 1'b0) count++;
      check({tag, "_sel"}, 32'(bus_b.SEG_SELECT_OUT), lit ? 32'h0 : 32'h1);
      check({tag, "_hex"}, 32'(bus_b.HEX_OUT), lit ? 32'h00 : 32'hFF);
    end
    check({tag, "_count"}, 32'(count), 32'(exp_count));
  endtask

  initial begin
    rst = 1'b1;
    bus_a.DIGITS_IN     = '0;
    bus_a.DOTS_IN       = '0;
    bus_a.LOAD_IN       = 1'b0;
    bus_a.DIGIT_EN_IN   = 4'hF;
    bus_a.BLANK_LZ_IN   = 1'b0;
    bus_a.BRIGHTNESS_IN = 3'd7;
    bus_b.DIGITS_IN     = 4'h8;
    bus_b.DOTS_IN       = 1'b1;
    bus_b.LOAD_IN       = 1'b1;
    bus_b.DIGIT_EN_IN   = 1'b1;
    bus_b.BLANK_LZ_IN   = 1'b0;
    bus_b.BRIGHTNESS_IN = 2'd3;
    #2;
    check("rst_sel", 32'(bus_a.SEG_SELECT_OUT), 32'hF);
    check("rst_hex", 32'(bus_a.HEX_OUT), 32'hFF);
    check("rst_tick", 32'(bus_a.SLOT_TICK_OUT), 32'h0);
    check("rst_hex_b", 32'(bus_b.HEX_OUT), 32'hFF);

    // 1234: digit0=4 ->99, digit1=3 ->B0, digit2=2 ->A4, digit3=1 ->F9; 20 edges covers the wrap.
    restart(16'h1234, 4'h0);
    scan("basic", 32'hF9A4B099, 4'hF, 20);

    // Mid-frame async reset while digit 1 is lit, then shadow restarts at zero.
    restart(16'h1234, 4'h0);
    scan("pre_rst", 32'hF9A4B099, 4'hF, 6);
    rst = 1'b1;
    #1;
    check("async_sel", 32'(bus_a.SEG_SELECT_OUT), 32'hF);
    check("async_hex", 32'(bus_a.HEX_OUT), 32'hFF);
    check("async_tick", 32'(bus_a.SLOT_TICK_OUT), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    scan("post_rst", 32'hC0C0C0C0, 4'hF, 8);

    // Leading zeros: 0050 -> digits 3,2 blanked, digit1=5 ->92, digit0=0 ->C0.
    bus_a.BLANK_LZ_IN = 1'b1;
    restart(16'h0050, 4'h0);
    scan("lz_on", 32'hFFFF92C0, 4'b0011, 16);
    bus_a.BLANK_LZ_IN = 1'b0;
    restart(16'h0050, 4'h0);
    scan("lz_off", 32'hC0C092C0, 4'hF, 16);

    bus_a.DIGIT_EN_IN = 4'b1011;
    restart(16'h1234, 4'h0);
    scan("enable", 32'hF9A4B099, 4'b1011, 16);
    bus_a.DIGIT_EN_IN = 4'hF;

    // Load 00FF during slot 0: edge 3 still shows old 4, edge 4 shows F with dot off ->8E.
    restart(16'h1234, 4'h0);
    scan("load_pre", 32'hF9A4B099, 4'hF, 2);
    bus_a.DIGITS_IN = 16'h00FF;
    bus_a.LOAD_IN   = 1'b1;
    @(posedge clk);
    #1;
    bus_a.LOAD_IN = 1'b0;
    check("load_edge1", 32'(bus_a.HEX_OUT), 32'h99);
    @(posedge clk);
    #1;
    check("load_edge2_hex", 32'(bus_a.HEX_OUT), 32'h8E);
    check("load_edge2_sel", 32'(bus_a.SEG_SELECT_OUT), 32'hE);

    // Nibble 8 with dot lit -> HEX_OUT 00 when lit; cnt 4,8,12 lit per slot at brightness 0.
    bright("bright0", 2'd0, 6);
    bright("bright2", 2'd2, 22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
